// File: rtl/glycemic_monitor_sequencer.sv
// Glycemic monitor: accepts a signed sensor sample, reports popcount of its magnitude,
// a four-sample floor average (only with GLYCEMIC_AVG_EN defined) and a sustained-high alarm.
module glycemic_monitor_sequencer #(
    parameter int unsigned THRESH = 6,
    parameter int unsigned HOLD   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sampleValid,
    input  logic [7:0] bloodSensor,
    output logic       sampleReady,
    output logic [3:0] glycemicIndex,
    output logic       indexValid,
    output logic [3:0] avgIndex,
    output logic       alarm
);

    localparam logic [2:0] HoldCnt = 3'(HOLD);

    typedef enum logic [1:0] {StIdle, StCalc, StReport} state_e;

    state_e     state_q, state_d;
    logic [7:0] sample_q;
    logic [7:0] mag;
    logic [3:0] index_q, index_d;
    logic [2:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (sampleValid) state_d = StCalc;
            StCalc:   state_d = StReport;
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // indexValid is gated by rst so a reset during REPORT suppresses the pulse.
    always_comb begin
        sampleReady = (state_q == StIdle);
        indexValid  = (state_q == StReport) && !rst;
    end

    always_comb begin
        mag     = sample_q[7] ? (~sample_q + 8'd1) : sample_q;
        index_d = 4'd0;
        for (int i = 0; i < 8; i++) begin
            index_d = index_d + 4'(mag[i]);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (32'(index_d) >= THRESH) begin
            cnt_d = (cnt_q >= HoldCnt) ? HoldCnt : cnt_q + 3'd1;
        end else begin
            cnt_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= 8'd0;
        end else if (sampleReady && sampleValid) begin
            sample_q <= bloodSensor;
        end
    end

    // All reported state commits on the CALC edge so it is valid alongside the REPORT pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            index_q <= 4'd0;
            cnt_q   <= 3'd0;
        end else if (state_q == StCalc) begin
            index_q <= index_d;
            cnt_q   <= cnt_d;
        end
    end

    assign glycemicIndex = index_q;
    assign alarm         = (cnt_q == HoldCnt);

`ifdef GLYCEMIC_AVG_EN
    logic [3:0] win_q [4];
    logic [5:0] win_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                win_q[i] <= 4'd0;
            end
        end else if (state_q == StCalc) begin
            win_q[0] <= index_d;
            for (int i = 1; i < 4; i++) begin
                win_q[i] <= win_q[i-1];
            end
        end
    end

    always_comb begin
        win_sum = 6'd0;
        for (int i = 0; i < 4; i++) begin
            win_sum = win_sum + 6'(win_q[i]);
        end
    end

    assign avgIndex = 4'(win_sum >> 2);
`else
    assign avgIndex = 4'd0;
`endif

endmodule

// File: tb/tb_glycemic_monitor_sequencer.sv
// Directed self-checking bench for glycemic_monitor_sequencer (avg checks follow GLYCEMIC_AVG_EN).
module tb_glycemic_monitor_sequencer;

`ifdef GLYCEMIC_AVG_EN
    localparam bit AvgEn = 1'b1;
`else
    localparam bit AvgEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sampleValid;
    logic [7:0] bloodSensor;
    logic       sampleReady;
    logic [3:0] glycemicIndex;
    logic       indexValid;
    logic [3:0] avgIndex;
    logic       alarm;

    int n_checks = 0;
    int n_fail   = 0;

    glycemic_monitor_sequencer #(.THRESH(6), .HOLD(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .sampleValid  (sampleValid),
        .bloodSensor  (bloodSensor),
        .sampleReady  (sampleReady),
        .glycemicIndex(glycemicIndex),
        .indexValid   (indexValid),
        .avgIndex     (avgIndex),
        .alarm        (alarm)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sampleValid = 1'b0;
        bloodSensor = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    // Offer one sample from IDLE; returns in the REPORT cycle.
    task automatic send(input logic [7:0] v);
        sampleValid = 1'b1;
        bloodSensor = v;
        tick();
        sampleValid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({sampleReady, indexValid, alarm, glycemicIndex, avgIndex} !== {3'b100, 4'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset: rdy/iv/alarm/gi/avg got %b/%b/%b/%0d/%0d want 1/0/0/0/0",
                     sampleReady, indexValid, alarm, glycemicIndex, avgIndex);
        end
    endtask

    task automatic test_basic();
        do_reset();
        sampleValid = 1'b1;
        bloodSensor = 8'h0F;
        tick();
        sampleValid = 1'b0;
        n_checks++;
        if ({sampleReady, indexValid} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_calc: rdy/iv got %b/%b want 0/0", sampleReady, indexValid);
        end
        tick();
        n_checks++;
        if ({indexValid, glycemicIndex, avgIndex, alarm} !== {1'b1, 4'd4, AvgEn ? 4'd1 : 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_report: iv/gi/avg/alarm got %b/%0d/%0d/%b want 1/4/%0d/0",
                     indexValid, glycemicIndex, avgIndex, alarm, AvgEn ? 1 : 0);
        end
        tick();
        n_checks++;
        if ({sampleReady, indexValid, glycemicIndex} !== {2'b10, 4'd4}) begin
            n_fail++;
            $display("FAIL basic_idle: rdy/iv/gi got %b/%b/%0d want 1/0/4",
                     sampleReady, indexValid, glycemicIndex);
        end
    endtask

    task automatic test_magnitude();
        logic [7:0] vals [8] = '{8'hFF, 8'h80, 8'h00, 8'h0F, 8'h81, 8'hF0, 8'h55, 8'hC3};
        logic [3:0] exp_gi [8] = '{4'd1, 4'd1, 4'd0, 4'd4, 4'd7, 4'd1, 4'd4, 4'd5};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(vals[i]);
            n_checks++;
            if ({indexValid, glycemicIndex} !== {1'b1, exp_gi[i]}) begin
                n_fail++;
                $display("FAIL magnitude[%02h]: iv/gi got %b/%0d want 1/%0d",
                         vals[i], indexValid, glycemicIndex, exp_gi[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        sampleValid = 1'b1;
        bloodSensor = 8'h7F;
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (sampleReady !== (i % 3 == 0) || indexValid !== (i % 3 == 2) ||
                (i % 3 == 2 && glycemicIndex !== 4'd7)) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: rdy/iv/gi got %b/%b/%0d want %b/%b/7",
                         i, sampleReady, indexValid, glycemicIndex, i % 3 == 0, i % 3 == 2);
            end
            tick();
        end
        sampleValid = 1'b0;
    endtask

    task automatic test_alarm();
        logic [7:0] vals [9] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h01, 8'h3F, 8'h3F, 8'h3F, 8'h1F};
        logic exp_al [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send(vals[i]);
            n_checks++;
            if (alarm !== exp_al[i]) begin
                n_fail++;
                $display("FAIL alarm[%0d]: got %b want %b", i, alarm, exp_al[i]);
            end
            tick();
            tick();
            n_checks++;
            if (alarm !== exp_al[i]) begin
                n_fail++;
                $display("FAIL alarm_hold[%0d]: got %b want %b", i, alarm, exp_al[i]);
            end
        end
    endtask

    task automatic test_avg();
        logic [7:0] vals [6] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h80};
        logic [3:0] exp_avg [6] = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd5, 4'd3};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(vals[i]);
            n_checks++;
            if (avgIndex !== (AvgEn ? exp_avg[i] : 4'd0)) begin
                n_fail++;
                $display("FAIL avg[%0d]: got %0d want %0d", i, avgIndex,
                         AvgEn ? exp_avg[i] : 4'd0);
            end
            tick();
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(8'h7F);
            tick();
        end
        sampleValid = 1'b1;
        bloodSensor = 8'h7F;
        tick();
        sampleValid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({sampleReady, indexValid, alarm, glycemicIndex, avgIndex} !== {3'b100, 4'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL abort_calc: rdy/iv/alarm/gi/avg got %b/%b/%b/%0d/%0d want 1/0/0/0/0",
                     sampleReady, indexValid, alarm, glycemicIndex, avgIndex);
        end
        tick();
        n_checks++;
        if (indexValid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_pulse: iv got %b want 0", indexValid);
        end
        send(8'h0F);
        n_checks++;
        if ({indexValid, glycemicIndex, avgIndex, alarm} !== {1'b1, 4'd4, AvgEn ? 4'd1 : 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_next: iv/gi/avg/alarm got %b/%0d/%0d/%b want 1/4/%0d/0",
                     indexValid, glycemicIndex, avgIndex, alarm, AvgEn ? 1 : 0);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (indexValid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_report: iv got %b want 0", indexValid);
        end
        tick();
        sampleValid = 1'b1;
        bloodSensor = 8'h7F;
        tick();
        rst = 1'b0;
        sampleValid = 1'b0;
        n_checks++;
        if ({sampleReady, glycemicIndex} !== {1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL rst_over_accept: rdy/gi got %b/%0d want 1/0", sampleReady, glycemicIndex);
        end
    endtask

    initial begin
        rst = 1'b1;
        sampleValid = 1'b0;
        bloodSensor = 8'h00;
        test_reset();
        test_basic();
        test_magnitude();
        test_back_to_back();
        test_alarm();
        test_avg();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
